// File: rtl/quantize_block_pkg.sv
// Shared quantizer definitions: fixed-point constants, zigzag scan, FSM encodings.
// Pure declarations, no logic.
// Imported by the interface, the coefficient datapath and the top level.
package quantize_block_pkg;

  localparam int BIT_WIDTH  = 16;
  localparam int BLOCK_SIZE = 4;
  localparam int NCOEF      = BLOCK_SIZE * BLOCK_SIZE;
  localparam int QFIX       = 17;
  localparam int MAX_LEVEL  = 2047;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // One quantizer parameter set (DC or AC)
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] iq;
    logic [31:0] bias;
    logic [31:0] zthr;
  } qparam_t;

  // Zigzag scan: scan position n -> raster position j
  function automatic logic [3:0] zz(input logic [3:0] n);
    logic [3:0] j;
    case (n)
      4'd0:  j = 4'd0;
      4'd1:  j = 4'd1;
      4'd2:  j = 4'd4;
      4'd3:  j = 4'd8;
      4'd4:  j = 4'd5;
      4'd5:  j = 4'd2;
      4'd6:  j = 4'd3;
      4'd7:  j = 4'd6;
      4'd8:  j = 4'd9;
      4'd9:  j = 4'd12;
      4'd10: j = 4'd13;
      4'd11: j = 4'd10;
      4'd12: j = 4'd7;
      4'd13: j = 4'd11;
      4'd14: j = 4'd14;
      default: j = 4'd15;
    endcase
    return j;
  endfunction

endpackage

// File: rtl/quantize_block_if.sv
// Request/result bundle between the transform stage and the quantizer.
// Wires only, no latency.
// start is a one-cycle request; done is a one-cycle completion pulse.
interface quantize_block_if;
  import quantize_block_pkg::*;

  logic                         start;
  logic [NCOEF*BIT_WIDTH-1:0]   in;
  logic [15:0]                  q_dc, q_ac, iq_dc, iq_ac;
  logic [31:0]                  bias_dc, bias_ac, zthr_dc, zthr_ac;
  logic [NCOEF*16-1:0]          sharpen;
  logic [NCOEF*BIT_WIDTH-1:0]   levels;
  logic [NCOEF*BIT_WIDTH-1:0]   dq;
  logic                         nz;
  logic                         busy;
  logic                         done;

  modport master (
    output start, in, q_dc, q_ac, iq_dc, iq_ac, bias_dc, bias_ac, zthr_dc, zthr_ac, sharpen,
    input  levels, dq, nz, busy, done
  );

  modport slave (
    input  start, in, q_dc, q_ac, iq_dc, iq_ac, bias_dc, bias_ac, zthr_dc, zthr_ac, sharpen,
    output levels, dq, nz, busy, done
  );

endinterface

// File: rtl/quantize_block_coeff.sv
// Single-coefficient quantizer: abs/sharpen/multiply, then bias/shift/clamp/sign/dequant.
// Latency 2 cycles, one coefficient accepted per cycle.
// No backpressure: results retire unconditionally two cycles after issue.
module quantize_block_coeff
  import quantize_block_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_vld,
  input  logic [3:0]           idx_n,
  input  logic [3:0]           idx_j,
  input  logic [BIT_WIDTH-1:0] coef,
  input  logic [15:0]          sharpen,
  input  qparam_t              qp,
  output logic                 ret_vld,
  output logic [3:0]           ret_n,
  output logic [3:0]           ret_j,
  output logic [BIT_WIDTH-1:0] level,
  output logic [BIT_WIDTH-1:0] dq,
  output logic                 lvl_nz
);

  logic [15:0] mag_c;
  logic [16:0] coeff_c;
  logic [32:0] prod_c;
  logic        keep_c;

  logic        s1_vld, s1_sign, s1_keep;
  logic [32:0] s1_prod;
  logic [31:0] s1_bias;
  logic [15:0] s1_q;
  logic [3:0]  s1_n, s1_j;

  logic [33:0] sum_c, sh_c;
  logic [15:0] lvl_c, level_c, dq_c;

  // Stage 1 combinational: magnitude (|-32768| fits unsigned 16), sharpen, multiply, threshold
  always_comb begin
    mag_c   = coef[BIT_WIDTH-1] ? (~coef + 16'd1) : coef;
    coeff_c = {1'b0, mag_c} + {1'b0, sharpen};
    prod_c  = {16'b0, coeff_c} * {17'b0, qp.iq};
    keep_c  = {15'b0, coeff_c} > qp.zthr;
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_keep <= 1'b0;
      s1_prod <= '0;
      s1_bias <= '0;
      s1_q    <= '0;
      s1_n    <= '0;
      s1_j    <= '0;
    end else begin
      s1_vld  <= issue_vld;
      s1_sign <= coef[BIT_WIDTH-1];
      s1_keep <= keep_c;
      s1_prod <= prod_c;
      s1_bias <= qp.bias;
      s1_q    <= qp.q;
      s1_n    <= idx_n;
      s1_j    <= idx_j;
    end
  end

  // Stage 2 combinational: round, shift, clamp, reapply sign, dequantize (16-bit wrap)
  always_comb begin
    sum_c = {1'b0, s1_prod} + {2'b0, s1_bias};
    sh_c  = sum_c >> QFIX;
    if (!s1_keep)
      lvl_c = '0;
    else if (sh_c > 34'(MAX_LEVEL))
      lvl_c = 16'(MAX_LEVEL);
    else
      lvl_c = sh_c[15:0];
    level_c = s1_sign ? (~lvl_c + 16'd1) : lvl_c;
    dq_c    = level_c * s1_q;
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_vld <= 1'b0;
      ret_n   <= '0;
      ret_j   <= '0;
      level   <= '0;
      dq      <= '0;
      lvl_nz  <= 1'b0;
    end else begin
      ret_vld <= s1_vld;
      ret_n   <= s1_n;
      ret_j   <= s1_j;
      level   <= level_c;
      dq      <= dq_c;
      lvl_nz  <= s1_vld && (lvl_c != 16'd0);
    end
  end

endmodule

// File: rtl/quantize_block.sv
// Quantizes a 16-coefficient block to VP8 levels (zigzag) and dequantized values (raster).
// Latency: done high in the cycle after the 18th edge following start acceptance.
// No backpressure; start is ignored while busy and re-accepted in the done cycle.
module quantize_block
  import quantize_block_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  quantize_block_if.slave bus
);

  state_t                     state, state_nxt;
  logic [3:0]                 n;
  logic [NCOEF*BIT_WIDTH-1:0] in_lat, levels_r, dq_r;
  logic [NCOEF*16-1:0]        sharpen_lat;
  qparam_t                    dc_lat, ac_lat;
  logic                       nz_r;

  logic                       accept;
  logic [3:0]                 j;
  logic                       ret_vld, ret_nz;
  logic [3:0]                 ret_n, ret_j;
  logic [BIT_WIDTH-1:0]       ret_level, ret_dq;

  assign accept = bus.start && (state == S_IDLE || state == S_FIN);
  assign j      = zz(n);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: issue 16 coefficients, drain the pipe, pulse done
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (n == 4'd15) state_nxt = S_DRAIN;
      S_DRAIN: if (ret_vld && ret_n == 4'd15) state_nxt = S_FIN;
      S_FIN:   state_nxt = bus.start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_RUN, S_DRAIN: bus.busy = 1'b1;
      S_FIN:          bus.done = 1'b1;
      default:        ;
    endcase
  end

  // Input latches and scan counter; the datapath only ever sees the latched copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n           <= '0;
      in_lat      <= '0;
      sharpen_lat <= '0;
      dc_lat      <= '0;
      ac_lat      <= '0;
    end else if (accept) begin
      n           <= '0;
      in_lat      <= bus.in;
      sharpen_lat <= bus.sharpen;
      dc_lat      <= '{q: bus.q_dc, iq: bus.iq_dc, bias: bus.bias_dc, zthr: bus.zthr_dc};
      ac_lat      <= '{q: bus.q_ac, iq: bus.iq_ac, bias: bus.bias_ac, zthr: bus.zthr_ac};
    end else if (state == S_RUN) begin
      n <= n + 4'd1;
    end
  end

  quantize_block_coeff u_coeff (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_vld (state == S_RUN),
    .idx_n     (n),
    .idx_j     (j),
    .coef      (in_lat[{j, 4'b0} +: BIT_WIDTH]),
    .sharpen   (sharpen_lat[{j, 4'b0} +: 16]),
    .qp        ((j == 4'd0) ? dc_lat : ac_lat),
    .ret_vld   (ret_vld),
    .ret_n     (ret_n),
    .ret_j     (ret_j),
    .level     (ret_level),
    .dq        (ret_dq),
    .lvl_nz    (ret_nz)
  );

  // Result registers: cleared on a new block, filled as coefficients retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      levels_r <= '0;
      dq_r     <= '0;
      nz_r     <= 1'b0;
    end else if (accept) begin
      levels_r <= '0;
      dq_r     <= '0;
      nz_r     <= 1'b0;
    end else if (ret_vld) begin
      levels_r[{ret_n, 4'b0} +: BIT_WIDTH] <= ret_level;
      dq_r[{ret_j, 4'b0} +: BIT_WIDTH]     <= ret_dq;
      nz_r                                 <= nz_r | ret_nz;
    end
  end

  assign bus.levels = levels_r;
  assign bus.dq     = dq_r;
  assign bus.nz     = nz_r;

endmodule
